// File: rtl/mem_req_arbiter.sv
// Two-client request arbiter in front of the memory request bridge.
// Buffers one request per client and keeps a single request outstanding at a time.
module mem_req_arbiter #(
    parameter int RR_MODE = 0
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        c0_request_enable,
    input  logic        c0_req_mode,
    input  logic [31:0] c0_req_addr,
    input  logic [31:0] c0_req_wdata,
    input  logic [3:0]  c0_req_wstrb,
    output logic        c0_busy,
    output logic        c0_response_enable,
    output logic [31:0] c0_resp_data,

    input  logic        c1_request_enable,
    input  logic        c1_req_mode,
    input  logic [31:0] c1_req_addr,
    input  logic [31:0] c1_req_wdata,
    input  logic [3:0]  c1_req_wstrb,
    output logic        c1_busy,
    output logic        c1_response_enable,
    output logic [31:0] c1_resp_data,

    output logic        request_enable,
    output logic        req_mode,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        response_enable,
    input  logic [31:0] resp_data
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } slot_t;

    state_t      state, state_nxt;
    slot_t       slot0, slot1, req_q, req_nxt;
    logic        pend0, pend1;
    logic        owner, owner_nxt;
    logic        rr_ptr, rr_ptr_nxt;
    logic        win;
    logic        rsp_done;
    logic        req_en_nxt;
    logic        c0_rsp_en_nxt, c1_rsp_en_nxt;
    logic [31:0] c0_rsp_data_nxt, c1_rsp_data_nxt;

    assign rsp_done = (state == ST_WAIT) && response_enable;
    assign c0_busy  = pend0;
    assign c1_busy  = pend1;

    // Slot is held until its response returns, so busy covers both buffered and in-flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (c0_request_enable && !pend0) begin
                pend0 <= 1'b1;
                slot0 <= {c0_req_mode, c0_req_addr, c0_req_wdata, c0_req_wstrb};
            end else if (rsp_done && !owner) begin
                pend0 <= 1'b0;
            end
            if (c1_request_enable && !pend1) begin
                pend1 <= 1'b1;
                slot1 <= {c1_req_mode, c1_req_addr, c1_req_wdata, c1_req_wstrb};
            end else if (rsp_done && owner) begin
                pend1 <= 1'b0;
            end
        end
    end

    always_comb begin
        if (pend0 && pend1) begin
            win = (RR_MODE != 0) ? rr_ptr : 1'b0;
        end else begin
            win = pend1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pend0 || pend1) state_nxt = ST_WAIT;
            ST_WAIT: if (response_enable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_en_nxt      = 1'b0;
        req_nxt         = req_q;
        owner_nxt       = owner;
        rr_ptr_nxt      = rr_ptr;
        c0_rsp_en_nxt   = 1'b0;
        c1_rsp_en_nxt   = 1'b0;
        c0_rsp_data_nxt = c0_resp_data;
        c1_rsp_data_nxt = c1_resp_data;
        case (state)
            ST_IDLE: begin
                if (pend0 || pend1) begin
                    req_en_nxt = 1'b1;
                    owner_nxt  = win;
                    req_nxt    = win ? slot1 : slot0;
                end
            end
            ST_WAIT: begin
                if (response_enable) begin
                    rr_ptr_nxt = ~owner;
                    if (owner) begin
                        c1_rsp_en_nxt   = 1'b1;
                        c1_rsp_data_nxt = resp_data;
                    end else begin
                        c0_rsp_en_nxt   = 1'b1;
                        c0_rsp_data_nxt = resp_data;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            request_enable     <= 1'b0;
            req_q              <= '0;
            owner              <= 1'b0;
            rr_ptr             <= 1'b0;
            c0_response_enable <= 1'b0;
            c1_response_enable <= 1'b0;
            c0_resp_data       <= '0;
            c1_resp_data       <= '0;
        end else begin
            request_enable     <= req_en_nxt;
            req_q              <= req_nxt;
            owner              <= owner_nxt;
            rr_ptr             <= rr_ptr_nxt;
            c0_response_enable <= c0_rsp_en_nxt;
            c1_response_enable <= c1_rsp_en_nxt;
            c0_resp_data       <= c0_rsp_data_nxt;
            c1_resp_data       <= c1_rsp_data_nxt;
        end
    end

    assign req_mode  = req_q.mode;
    assign req_addr  = req_q.addr;
    assign req_wdata = req_q.wdata;
    assign req_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: fixed-priority and round-robin instances share all inputs.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        c0_request_enable, c0_req_mode, c1_request_enable, c1_req_mode;
    logic [31:0] c0_req_addr, c0_req_wdata, c1_req_addr, c1_req_wdata;
    logic [3:0]  c0_req_wstrb, c1_req_wstrb;
    logic        response_enable;
    logic [31:0] resp_data;

    logic        fp_c0_busy, fp_c0_rsp_en, fp_c1_busy, fp_c1_rsp_en, fp_req_en, fp_req_mode;
    logic [31:0] fp_c0_rsp_data, fp_c1_rsp_data, fp_req_addr, fp_req_wdata;
    logic [3:0]  fp_req_wstrb;
    logic        rr_c0_busy, rr_c0_rsp_en, rr_c1_busy, rr_c1_rsp_en, rr_req_en, rr_req_mode;
    logic [31:0] rr_c0_rsp_data, rr_c1_rsp_data, rr_req_addr, rr_req_wdata;
    logic [3:0]  rr_req_wstrb;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.RR_MODE(0)) u_fp (
        .clk(clk), .rstn(rstn),
        .c0_request_enable(c0_request_enable), .c0_req_mode(c0_req_mode), .c0_req_addr(c0_req_addr),
        .c0_req_wdata(c0_req_wdata), .c0_req_wstrb(c0_req_wstrb), .c0_busy(fp_c0_busy),
        .c0_response_enable(fp_c0_rsp_en), .c0_resp_data(fp_c0_rsp_data),
        .c1_request_enable(c1_request_enable), .c1_req_mode(c1_req_mode), .c1_req_addr(c1_req_addr),
        .c1_req_wdata(c1_req_wdata), .c1_req_wstrb(c1_req_wstrb), .c1_busy(fp_c1_busy),
        .c1_response_enable(fp_c1_rsp_en), .c1_resp_data(fp_c1_rsp_data),
        .request_enable(fp_req_en), .req_mode(fp_req_mode), .req_addr(fp_req_addr),
        .req_wdata(fp_req_wdata), .req_wstrb(fp_req_wstrb),
        .response_enable(response_enable), .resp_data(resp_data)
    );

    mem_req_arbiter #(.RR_MODE(1)) u_rr (
        .clk(clk), .rstn(rstn),
        .c0_request_enable(c0_request_enable), .c0_req_mode(c0_req_mode), .c0_req_addr(c0_req_addr),
        .c0_req_wdata(c0_req_wdata), .c0_req_wstrb(c0_req_wstrb), .c0_busy(rr_c0_busy),
        .c0_response_enable(rr_c0_rsp_en), .c0_resp_data(rr_c0_rsp_data),
        .c1_request_enable(c1_request_enable), .c1_req_mode(c1_req_mode), .c1_req_addr(c1_req_addr),
        .c1_req_wdata(c1_req_wdata), .c1_req_wstrb(c1_req_wstrb), .c1_busy(rr_c1_busy),
        .c1_response_enable(rr_c1_rsp_en), .c1_resp_data(rr_c1_rsp_data),
        .request_enable(rr_req_en), .req_mode(rr_req_mode), .req_addr(rr_req_addr),
        .req_wdata(rr_req_wdata), .req_wstrb(rr_req_wstrb),
        .response_enable(response_enable), .resp_data(resp_data)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bridge model: waits (bounded) for a request, then replies one cycle after it.
    task automatic serve(input logic [31:0] rdata, output logic [31:0] fp_addr,
                         output logic [31:0] rr_addr, output int unsigned waits, output logic ok);
        waits = 0;
        while (!fp_req_en && waits < 20) begin
            tick();
            waits++;
        end
        ok      = fp_req_en;
        fp_addr = fp_req_addr;
        rr_addr = rr_req_addr;
        tick();
        response_enable = 1'b1;
        resp_data       = rdata;
        tick();
        response_enable = 1'b0;
    endtask

    logic [31:0] fa, ra;
    int unsigned wt, cnt;
    logic        ok;
    logic [31:0] exp_order [4];

    initial begin
        exp_order[0] = 32'h400; exp_order[1] = 32'h800;
        exp_order[2] = 32'h400; exp_order[3] = 32'h800;
        rstn = 1'b0;
        c0_request_enable = 0; c0_req_mode = 0; c0_req_addr = '0; c0_req_wdata = '0; c0_req_wstrb = '0;
        c1_request_enable = 0; c1_req_mode = 0; c1_req_addr = '0; c1_req_wdata = '0; c1_req_wstrb = '0;
        response_enable = 0; resp_data = '0;
        #12;
        check("rst_fp_outputs", {31'b0, |{fp_c0_busy, fp_c0_rsp_en, fp_c0_rsp_data, fp_c1_busy, fp_c1_rsp_en,
              fp_c1_rsp_data, fp_req_en, fp_req_mode, fp_req_addr, fp_req_wdata, fp_req_wstrb}}, 32'd0);
        check("rst_rr_outputs", {31'b0, |{rr_c0_busy, rr_c0_rsp_en, rr_c0_rsp_data, rr_c1_busy, rr_c1_rsp_en,
              rr_c1_rsp_data, rr_req_en, rr_req_mode, rr_req_addr, rr_req_wdata, rr_req_wstrb}}, 32'd0);
        @(negedge clk) rstn = 1'b1;
        tick();

        // T1: c0 read with exact latency
        c0_request_enable = 1; c0_req_mode = 0; c0_req_addr = 32'h0000_1000;
        tick();
        c0_request_enable = 0;
        check("t1_busy", {31'b0, fp_c0_busy}, 32'd1);
        check("t1_req_not_yet", {31'b0, fp_req_en}, 32'd0);
        tick();
        check("t1_req_en", {31'b0, fp_req_en}, 32'd1);
        check("t1_req_addr", fp_req_addr, 32'h0000_1000);
        check("t1_req_mode", {31'b0, fp_req_mode}, 32'd0);
        tick();
        check("t1_req_pulse", {31'b0, fp_req_en}, 32'd0);
        check("t1_addr_hold", fp_req_addr, 32'h0000_1000);
        response_enable = 1; resp_data = 32'hDEAD_BEEF;
        tick();
        response_enable = 0;
        check("t1_c0_rsp_en", {31'b0, fp_c0_rsp_en}, 32'd1);
        check("t1_c0_rsp_data", fp_c0_rsp_data, 32'hDEAD_BEEF);
        check("t1_c0_busy_clr", {31'b0, fp_c0_busy}, 32'd0);
        check("t1_c1_untouched", {30'b0, fp_c1_rsp_en, fp_c1_busy} | fp_c1_rsp_data, 32'd0);
        tick();
        check("t1_rsp_pulse", {31'b0, fp_c0_rsp_en}, 32'd0);
        check("t1_rsp_hold", fp_c0_rsp_data, 32'hDEAD_BEEF);
        check("t1_no_reissue", {31'b0, fp_req_en}, 32'd0);

        // T2: c1 write forwarded exactly
        c1_request_enable = 1; c1_req_mode = 1; c1_req_addr = 32'h20;
        c1_req_wdata = 32'h1234_5678; c1_req_wstrb = 4'b0011;
        tick();
        c1_request_enable = 0;
        tick();
        check("t2_req_en", {31'b0, fp_req_en}, 32'd1);
        check("t2_req_mode", {31'b0, fp_req_mode}, 32'd1);
        check("t2_req_addr", fp_req_addr, 32'h20);
        check("t2_req_wdata", fp_req_wdata, 32'h1234_5678);
        check("t2_req_wstrb", {28'b0, fp_req_wstrb}, 32'h3);
        tick();
        response_enable = 1; resp_data = 32'hA5A5_A5A5;
        tick();
        response_enable = 0;
        check("t2_c1_rsp_en", {31'b0, fp_c1_rsp_en}, 32'd1);
        check("t2_c1_rsp_data", fp_c1_rsp_data, 32'hA5A5_A5A5);
        check("t2_c0_quiet", {31'b0, fp_c0_rsp_en}, 32'd0);
        check("t2_c0_data_held", fp_c0_rsp_data, 32'hDEAD_BEEF);

        // T3: simultaneous pulses, fixed priority serves c0 then c1
        c1_req_mode = 0;
        for (int r = 0; r < 3; r++) begin
            c0_request_enable = 1; c0_req_addr = 32'h100 + r;
            c1_request_enable = 1; c1_req_addr = 32'h200 + r;
            tick();
            c0_request_enable = 0; c1_request_enable = 0;
            serve(32'hC000 + r, fa, ra, wt, ok);
            check("t3_first_ok", {31'b0, ok}, 32'd1);
            check("t3_first_addr", fa, 32'h100 + r);
            check("t3_first_route", {30'b0, fp_c0_rsp_en, fp_c1_rsp_en}, 32'd2);
            serve(32'hC100 + r, fa, ra, wt, ok);
            check("t3_second_ok", {31'b0, ok}, 32'd1);
            check("t3_second_addr", fa, 32'h200 + r);
            check("t3_second_route", {30'b0, fp_c0_rsp_en, fp_c1_rsp_en}, 32'd1);
            check("t3_c1_data", fp_c1_rsp_data, 32'hC100 + r);
        end

        // T4: continuous pulsing alternates; issue resumes no earlier than the cycle after R+1
        c0_request_enable = 1; c0_req_addr = 32'h400;
        c1_request_enable = 1; c1_req_addr = 32'h800;
        tick();
        for (int i = 0; i < 4; i++) begin
            serve(32'hB000 + i, fa, ra, wt, ok);
            check("t4_ok", {31'b0, ok}, 32'd1);
            check("t4_waits", wt, 32'd1);
            check("t4_fp_order", fa, exp_order[i]);
            check("t4_rr_order", ra, exp_order[i]);
            check("t4_gap", {31'b0, fp_req_en}, 32'd0);
        end
        c0_request_enable = 0; c1_request_enable = 0;
        serve(32'hB004, fa, ra, wt, ok);
        check("t4_drain_fp", fa, 32'h400);
        check("t4_drain_rr", ra, 32'h400);

        // T4b: after c0 served alone, round-robin favours c1 while fixed priority keeps c0
        c0_request_enable = 1; c0_req_addr = 32'h440;
        c1_request_enable = 1; c1_req_addr = 32'h880;
        tick();
        c0_request_enable = 0; c1_request_enable = 0;
        serve(32'hE000, fa, ra, wt, ok);
        check("t4b_fp_first", fa, 32'h440);
        check("t4b_rr_first", ra, 32'h880);
        check("t4b_rr_route", {30'b0, rr_c0_rsp_en, rr_c1_rsp_en}, 32'd1);
        check("t4b_rr_data", rr_c1_rsp_data, 32'hE000);
        serve(32'hE001, fa, ra, wt, ok);
        check("t4b_fp_second", fa, 32'h880);
        check("t4b_rr_second", ra, 32'h440);

        // T5: pulse while busy is dropped
        c0_request_enable = 1; c0_req_addr = 32'h500;
        tick();
        check("t5_busy", {31'b0, fp_c0_busy}, 32'd1);
        c0_req_addr = 32'h999;
        tick();
        c0_request_enable = 0;
        serve(32'h55AA_0001, fa, ra, wt, ok);
        check("t5_ok", {31'b0, ok}, 32'd1);
        check("t5_addr", fa, 32'h500);
        check("t5_rsp_data", fp_c0_rsp_data, 32'h55AA_0001);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fp_req_en) cnt++;
        end
        check("t5_no_extra_req", cnt, 32'd0);
        check("t5_idle_busy", {31'b0, fp_c0_busy}, 32'd0);

        // T6: asynchronous reset mid-WAIT, late response ignored
        c0_request_enable = 1; c0_req_addr = 32'h600;
        tick();
        c0_request_enable = 0;
        tick();
        check("t6_req_en", {31'b0, fp_req_en}, 32'd1);
        tick();
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_addr", fp_req_addr, 32'd0);
        check("t6_rst_busy", {31'b0, fp_c0_busy}, 32'd0);
        check("t6_rst_data", fp_c0_rsp_data, 32'd0);
        check("t6_rst_rr", {31'b0, |{rr_req_addr, rr_c0_busy, rr_c0_rsp_data, rr_c1_rsp_data}}, 32'd0);
        @(negedge clk) rstn = 1'b1;
        tick();
        response_enable = 1; resp_data = 32'h7777_7777;
        tick();
        response_enable = 0;
        check("t6_late_rsp", {30'b0, fp_c0_rsp_en, fp_c1_rsp_en}, 32'd0);
        check("t6_late_data", fp_c0_rsp_data, 32'd0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fp_req_en || rr_req_en) cnt++;
        end
        check("t6_no_req", cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
